// File: rtl/soc_otg_hpi_pkg.sv
// Shared definitions for the CY7C67200 HPI bus master: FSM encoding,
// HPI register addresses and default bus timing.
`timescale 1ns/1ps
package soc_otg_hpi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_DONE   = 3'd4
    } hpi_state_t;

    localparam logic [1:0] HPI_DATA    = 2'd0;
    localparam logic [1:0] HPI_MAILBOX = 2'd1;
    localparam logic [1:0] HPI_ADDRESS = 2'd2;
    localparam logic [1:0] HPI_STATUS  = 2'd3;

    localparam int DEF_SETUP_CYCLES  = 2;
    localparam int DEF_STROBE_CYCLES = 6;
    localparam int DEF_HOLD_CYCLES   = 2;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/soc_otg_hpi_int_sync.sv
// Two-flop synchronizer bringing the asynchronous HPI interrupt into the clk domain.
`timescale 1ns/1ps
module soc_otg_hpi_int_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/soc_otg_hpi_master.sv
// Avalon-MM slave that runs timed CY7C67200 HPI read/write cycles and stalls
// the CPU with waitrequest until the bus cycle has finished.
`timescale 1ns/1ps
module soc_otg_hpi_master
    import soc_otg_hpi_pkg::*;
#(
    parameter int SETUP_CYCLES  = DEF_SETUP_CYCLES,
    parameter int STROBE_CYCLES = DEF_STROBE_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES
) (
    input  logic        clk,
    input  logic        reset_n,
    // Avalon-MM slave: a transfer is accepted in the cycle where
    // chipselect & (read|write) is high and waitrequest is low.
    input  logic [1:0]  avs_address,
    input  logic        avs_chipselect,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [15:0] avs_writedata,
    output logic [15:0] avs_readdata,
    output logic        avs_waitrequest,
    output logic [1:0]  hpi_addr,
    output logic        hpi_cs_n,
    output logic        hpi_rd_n,
    output logic        hpi_wr_n,
    input  logic [15:0] hpi_data_in,
    output logic [15:0] hpi_data_out,
    output logic        hpi_data_oe,
    input  logic        hpi_int,
    output logic        irq,
    output logic [2:0]  o_dbg_state
);

    localparam int CNT_MAX = max3(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES);
    localparam int CW      = $clog2(CNT_MAX + 1);

    hpi_state_t      r_state;
    hpi_state_t      w_state_next;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_next;

    logic            r_is_write;
    logic [1:0]      r_addr;
    logic [15:0]     r_wdata;
    logic [15:0]     r_rdata;
    logic            r_cs_n;
    logic            r_rd_n;
    logic            r_wr_n;
    logic            r_oe;

    logic            w_req;
    logic            w_last;
    logic            w_dir_wr;
    logic            w_bus_next;
    logic            w_capture;

    assign w_req  = avs_chipselect & (avs_read | avs_write);
    assign w_last = (r_cnt == CW'(1));

    // Direction for the coming cycle: in IDLE the request has not been latched yet.
    assign w_dir_wr   = (r_state == ST_IDLE) ? avs_write : r_is_write;
    assign w_bus_next = (w_state_next == ST_SETUP) || (w_state_next == ST_STROBE) ||
                        (w_state_next == ST_HOLD);
    assign w_capture  = (r_state == ST_STROBE) && w_last && !r_is_write;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_state_next = ST_SETUP;
                    w_cnt_next   = CW'(SETUP_CYCLES);
                end
            end
            ST_SETUP: begin
                if (w_last) begin
                    w_state_next = ST_STROBE;
                    w_cnt_next   = CW'(STROBE_CYCLES);
                end else begin
                    w_cnt_next   = r_cnt - CW'(1);
                end
            end
            ST_STROBE: begin
                if (w_last) begin
                    w_state_next = ST_HOLD;
                    w_cnt_next   = CW'(HOLD_CYCLES);
                end else begin
                    w_cnt_next   = r_cnt - CW'(1);
                end
            end
            ST_HOLD: begin
                if (w_last) begin
                    w_state_next = ST_DONE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next   = r_cnt - CW'(1);
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Request fields are frozen for the whole bus cycle, even if the master drops req.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_is_write <= 1'b0;
            r_addr     <= 2'd0;
            r_wdata    <= 16'd0;
        end else if ((r_state == ST_IDLE) && w_req) begin
            r_is_write <= avs_write;
            r_addr     <= avs_address;
            if (avs_write) begin
                r_wdata <= avs_writedata;
            end
        end
    end

    // Pin outputs are registered from the next state so the pads see clean edges.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cs_n <= 1'b1;
            r_rd_n <= 1'b1;
            r_wr_n <= 1'b1;
            r_oe   <= 1'b0;
        end else begin
            r_cs_n <= !w_bus_next;
            r_rd_n <= !((w_state_next == ST_STROBE) && !w_dir_wr);
            r_wr_n <= !((w_state_next == ST_STROBE) && w_dir_wr);
            r_oe   <= w_bus_next && w_dir_wr;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rdata <= 16'd0;
        end else if (w_capture) begin
            r_rdata <= hpi_data_in;
        end
    end

    soc_otg_hpi_int_sync u_int_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_async (hpi_int),
        .o_sync  (irq)
    );

    assign avs_waitrequest = w_req && (r_state != ST_DONE);
    assign avs_readdata    = r_rdata;
    assign hpi_addr        = r_addr;
    assign hpi_cs_n        = r_cs_n;
    assign hpi_rd_n        = r_rd_n;
    assign hpi_wr_n        = r_wr_n;
    assign hpi_data_out    = r_wdata;
    assign hpi_data_oe     = r_oe;
    assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_soc_otg_hpi_master.sv
// Bench for soc_otg_hpi_master: random and directed Avalon transfers against an
// HPI chip model, with Avalon and HPI-bus monitors checking against expected queues.
`timescale 1ns/1ps
module tb_soc_otg_hpi_master;
  import soc_otg_hpi_pkg::*;

  localparam int T_SETUP  = 2;
  localparam int T_STROBE = 6;
  localparam int T_HOLD   = 2;
  localparam int CS_LEN   = T_SETUP + T_STROBE + T_HOLD;
  localparam int LATENCY  = 1 + T_SETUP + T_STROBE + T_HOLD;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  avs_address = 2'd0;
  logic        avs_chipselect = 1'b0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [15:0] avs_writedata = 16'd0;
  logic [15:0] avs_readdata;
  logic        avs_waitrequest;
  logic [1:0]  hpi_addr;
  logic        hpi_cs_n;
  logic        hpi_rd_n;
  logic        hpi_wr_n;
  logic [15:0] hpi_data_in;
  logic [15:0] hpi_data_out;
  logic        hpi_data_oe;
  logic        hpi_int = 1'b0;
  logic        irq;
  logic [2:0]  dbg_state;

  soc_otg_hpi_master dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .avs_address     (avs_address),
    .avs_chipselect  (avs_chipselect),
    .avs_read        (avs_read),
    .avs_write       (avs_write),
    .avs_writedata   (avs_writedata),
    .avs_readdata    (avs_readdata),
    .avs_waitrequest (avs_waitrequest),
    .hpi_addr        (hpi_addr),
    .hpi_cs_n        (hpi_cs_n),
    .hpi_rd_n        (hpi_rd_n),
    .hpi_wr_n        (hpi_wr_n),
    .hpi_data_in     (hpi_data_in),
    .hpi_data_out    (hpi_data_out),
    .hpi_data_oe     (hpi_data_oe),
    .hpi_int         (hpi_int),
    .irq             (irq),
    .o_dbg_state     (dbg_state)
  );

  // ---------------- HPI chip model ----------------
  logic [15:0] chip_regs [4] = '{16'hBEEF, 16'h0A5C, 16'h7E11, 16'h3C96};
  assign hpi_data_in = (!hpi_cs_n && !hpi_rd_n) ? chip_regs[hpi_addr] : 16'hDEAD;
  always @(posedge hpi_wr_n) begin
    if (reset_n === 1'b1 && hpi_cs_n === 1'b0) chip_regs[hpi_addr] = hpi_data_out;
  end

  // ---------------- reference model and scoreboard ----------------
  logic [15:0] model_regs [4] = '{16'hBEEF, 16'h0A5C, 16'h7E11, 16'h3C96};
  logic [15:0] model_last_rd = 16'd0;
  logic [15:0] exp_q [$];   // expected avs_readdata at each Avalon completion
  logic [18:0] bus_q [$];   // expected {is_write, addr, data} of each HPI bus cycle

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the edge that accepts the transfer.
  task automatic xfer(input bit wr, input bit rd, input logic [1:0] a, input logic [15:0] d,
                      input bit keep);
    int n;
    avs_chipselect = 1'b1;
    avs_read = rd;
    avs_write = wr;
    avs_address = a;
    avs_writedata = d;
    if (wr) model_regs[a] = d;
    else model_last_rd = model_regs[a];
    exp_q.push_back(model_last_rd);
    bus_q.push_back({wr, a, wr ? d : 16'd0});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (avs_waitrequest && n < 40);
    chk("xfer_wait_end", avs_waitrequest, 0);
    @(posedge clk);
    #1;
    if (!keep) drop_req();
  endtask

  task automatic drop_req();
    avs_chipselect = 1'b0;
    avs_read = 1'b0;
    avs_write = 1'b0;
  endtask

  // ---------------- Avalon monitor ----------------
  int wait_cnt = 0;
  always @(negedge clk) begin
    if (!reset_n) begin
      wait_cnt = 0;
    end else if (avs_chipselect && (avs_read || avs_write)) begin
      if (avs_waitrequest) begin
        wait_cnt++;
      end else begin
        if (exp_q.size() == 0) chk("avs_unexpected_done", 1, 0);
        else chk("avs_readdata", avs_readdata, exp_q.pop_front());
        chk("avs_latency", wait_cnt, LATENCY);
        wait_cnt = 0;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // ---------------- HPI bus monitor ----------------
  bit in_cyc = 0;
  int cs_len, st_start, st_len, hi_run = 100, last_gap = 0;
  bit st_wr, st_rd, both_low, oe_all, oe_any, addr_var, data_var, idle_bad = 0;
  logic [1:0] c_addr;
  logic [15:0] c_data;
  logic [18:0] be;

  always @(negedge clk) begin
    if (!reset_n) begin
      in_cyc = 0;
      hi_run = 100;
    end else if (!hpi_cs_n) begin
      if (!in_cyc) begin
        in_cyc = 1;
        cs_len = 0; st_start = 0; st_len = 0;
        st_wr = 0; st_rd = 0; both_low = 0;
        oe_all = 1; oe_any = 0; addr_var = 0; data_var = 0;
        c_addr = hpi_addr; c_data = hpi_data_out;
        last_gap = hi_run;
        chk("bus_gap_min2", (hi_run >= 2), 1);
      end
      cs_len++;
      if (!hpi_rd_n || !hpi_wr_n) begin
        if (st_start == 0) st_start = cs_len;
        st_len++;
      end
      if (!hpi_wr_n) st_wr = 1;
      if (!hpi_rd_n) st_rd = 1;
      if (!hpi_wr_n && !hpi_rd_n) both_low = 1;
      oe_all &= hpi_data_oe;
      oe_any |= hpi_data_oe;
      if (hpi_addr !== c_addr) addr_var = 1;
      if (hpi_data_out !== c_data) data_var = 1;
    end else begin
      if (in_cyc) begin
        in_cyc = 0;
        hi_run = 0;
        if (bus_q.size() == 0) begin
          chk("bus_unexpected_cycle", 1, 0);
        end else begin
          be = bus_q.pop_front();
          chk("bus_cs_len", cs_len, CS_LEN);
          chk("bus_strobe_start", st_start, T_SETUP + 1);
          chk("bus_strobe_len", st_len, T_STROBE);
          chk("bus_wr_strobe", st_wr, be[18]);
          chk("bus_rd_strobe", st_rd, !be[18]);
          chk("bus_addr", {addr_var, c_addr}, {1'b0, be[17:16]});
          chk("bus_both_low", both_low, 0);
          if (be[18]) begin
            chk("bus_oe_write", oe_all, 1);
            chk("bus_wdata", {data_var, c_data}, {1'b0, be[15:0]});
          end else begin
            chk("bus_oe_read", oe_any, 0);
          end
        end
      end
      hi_run++;
      if (!hpi_rd_n || !hpi_wr_n || hpi_data_oe) idle_bad = 1;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int op;
    bit keep;
    logic [1:0] ra;
    logic [15:0] rd16;

    // Reset values while held in reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs_n", hpi_cs_n, 1);
    chk("rst_rd_n", hpi_rd_n, 1);
    chk("rst_wr_n", hpi_wr_n, 1);
    chk("rst_oe", hpi_data_oe, 0);
    chk("rst_readdata", avs_readdata, 0);
    chk("rst_irq", irq, 0);
    chk("rst_addr", hpi_addr, 0);
    chk("rst_data_out", hpi_data_out, 0);
    chk("rst_state", dbg_state, ST_IDLE);

    @(negedge clk) reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("idle_cs_n", hpi_cs_n, 1);
    chk("idle_strobes", {hpi_rd_n, hpi_wr_n}, 2'b11);
    chk("idle_oe", hpi_data_oe, 0);
    chk("idle_waitrequest", avs_waitrequest, 0);

    // Directed write, then read of the chip's 0xBEEF
    xfer(1, 0, HPI_ADDRESS, 16'h1234, 0);
    repeat (2) @(posedge clk);
    #1;
    xfer(0, 1, HPI_DATA, 16'h0, 0);
    chk("read_beef", avs_readdata, 16'hBEEF);

    // Back-to-back write then read with req held
    xfer(1, 0, HPI_MAILBOX, 16'hC0DE, 1);
    xfer(0, 1, HPI_MAILBOX, 16'h0, 0);
    chk("b2b_cs_gap", last_gap, 2);

    // Read and write together is a write
    repeat (1) @(posedge clk);
    #1;
    xfer(1, 1, HPI_STATUS, 16'h5A5A, 0);
    xfer(0, 1, HPI_STATUS, 16'h0, 0);

    // Request dropped during SETUP: read still runs to completion
    avs_chipselect = 1'b1; avs_read = 1'b1; avs_write = 1'b0; avs_address = HPI_ADDRESS;
    model_last_rd = model_regs[HPI_ADDRESS];
    bus_q.push_back({1'b0, HPI_ADDRESS, 16'd0});
    @(posedge clk);
    #1;
    drop_req();
    repeat (15) @(posedge clk);
    #1;
    chk("drop_readdata", avs_readdata, model_last_rd);
    chk("drop_state_idle", dbg_state, ST_IDLE);
    chk("drop_cs_n", hpi_cs_n, 1);

    // Async reset during the STROBE phase of a write
    avs_chipselect = 1'b1; avs_read = 1'b0; avs_write = 1'b1;
    avs_address = HPI_MAILBOX; avs_writedata = 16'hFFFF;
    repeat (5) @(posedge clk);
    #1;
    chk("abort_in_strobe", hpi_wr_n, 0);
    #1;
    reset_n = 1'b0;
    model_last_rd = 16'd0;
    #1;
    chk("abort_wr_n", hpi_wr_n, 1);
    chk("abort_cs_n", hpi_cs_n, 1);
    chk("abort_oe", hpi_data_oe, 0);
    chk("abort_readdata", avs_readdata, 0);
    drop_req();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    xfer(0, 1, HPI_MAILBOX, 16'h0, 0);
    chk("abort_reg_intact", avs_readdata, 16'hC0DE);

    // hpi_int to irq through two flops
    hpi_int = 1'b1;
    @(posedge clk);
    #1;
    chk("irq_after_1", irq, 0);
    @(posedge clk);
    #1;
    chk("irq_after_2", irq, 1);
    hpi_int = 1'b0;
    @(posedge clk);
    #1;
    chk("irq_fall_1", irq, 1);
    @(posedge clk);
    #1;
    chk("irq_fall_2", irq, 0);

    // Random traffic
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 2);
      ra = 2'($urandom_range(0, 3));
      rd16 = 16'($urandom);
      keep = (i != 39) && ($urandom_range(0, 1) == 1);
      xfer(op != 0, op != 1, ra, rd16, keep);
      if (!keep) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
    end
    drop_req();
    repeat (20) @(posedge clk);
    #1;

    chk("avs_queue_empty", exp_q.size(), 0);
    chk("bus_queue_empty", bus_q.size(), 0);
    chk("idle_bus_quiet", idle_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
